// File: rtl/trivium_pkg.sv
// Shared constants, tap positions and helpers for the Trivium keystream generator.
// Tap constants use the 1-based cipher numbering s1..s288; bit n of a state vector holds s(n+1).
package trivium_pkg;

  localparam int STATE_W         = 288;
  localparam int KEY_W           = 80;
  localparam int IV_W            = 80;
  localparam int DEF_INIT_ROUNDS = 1152;

  // Last stage of the first two shift banks (s1..s93, s94..s177)
  localparam int A_END = 93;
  localparam int B_END = 177;

  localparam int T1_A    = 66;
  localparam int T1_B    = 93;
  localparam int T1_AND0 = 91;
  localparam int T1_AND1 = 92;
  localparam int T1_FB   = 171;
  localparam int T2_A    = 162;
  localparam int T2_B    = 177;
  localparam int T2_AND0 = 175;
  localparam int T2_AND1 = 176;
  localparam int T2_FB   = 264;
  localparam int T3_A    = 243;
  localparam int T3_B    = 288;
  localparam int T3_AND0 = 286;
  localparam int T3_AND1 = 287;
  localparam int T3_FB   = 69;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN
  } fsm_t;

  // Key into s1..s80, IV into s94..s173, s286..s288 set, everything else clear
  function automatic logic [STATE_W-1:0] load_state(input logic [KEY_W-1:0] key,
                                                    input logic [IV_W-1:0]  iv);
    logic [STATE_W-1:0] s;
    s                          = '0;
    s[KEY_W-1:0]               = key;
    s[A_END+IV_W-1:A_END]      = iv;
    s[STATE_W-1:STATE_W-3]     = 3'b111;
    return s;
  endfunction

endpackage

// File: rtl/trivium_round.sv
// One combinational Trivium round: produces the keystream bit z and the shifted state.
module trivium_round
  import trivium_pkg::*;
(
  input  logic [STATE_W-1:0] i_state,
  output logic [STATE_W-1:0] o_state,
  output logic               o_z
);

  logic w_t1;
  logic w_t2;
  logic w_t3;
  logic w_fb1;
  logic w_fb2;
  logic w_fb3;

  assign w_t1 = i_state[T1_A-1] ^ i_state[T1_B-1];
  assign w_t2 = i_state[T2_A-1] ^ i_state[T2_B-1];
  assign w_t3 = i_state[T3_A-1] ^ i_state[T3_B-1];
  assign o_z  = w_t1 ^ w_t2 ^ w_t3;

  assign w_fb1 = w_t1 ^ (i_state[T1_AND0-1] & i_state[T1_AND1-1]) ^ i_state[T1_FB-1];
  assign w_fb2 = w_t2 ^ (i_state[T2_AND0-1] & i_state[T2_AND1-1]) ^ i_state[T2_FB-1];
  assign w_fb3 = w_t3 ^ (i_state[T3_AND0-1] & i_state[T3_AND1-1]) ^ i_state[T3_FB-1];

  // Each bank shifts up by one; its first stage takes the feedback of the previous bank
  assign o_state = {i_state[STATE_W-2:B_END], w_fb2,
                    i_state[B_END-2:A_END],   w_fb1,
                    i_state[A_END-2:0],       w_fb3};

endmodule

// File: rtl/trivium_stream_gen.sv
// WIDTH-bit-per-cycle Trivium keystream generator with internal warm-up FSM and optional in-place XOR.
// First word N+1 cycles after load (N = INIT_ROUNDS/WIDTH); word and state hold while out_valid & !out_ready.
module trivium_stream_gen
  import trivium_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int INIT_ROUNDS = DEF_INIT_ROUNDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic [IV_W-1:0]  iv_in,
  input  logic             mode_in,
  input  logic             load,
  output logic             busy,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] ks_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int N_ADV = INIT_ROUNDS / WIDTH;
  localparam int CNT_W = (N_ADV > 1) ? $clog2(N_ADV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((N_ADV > 0) ? N_ADV - 1 : 0);

  fsm_t               r_state;
  logic [STATE_W-1:0] r_s;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mode;
  logic               r_busy;

  logic [STATE_W-1:0] w_chain [WIDTH+1];
  logic [WIDTH-1:0]   w_z;
  logic               w_run;
  logic               w_word_vld;
  logic               w_adv;

  assign w_chain[0] = r_s;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_round
      trivium_round u_round (
        .i_state (w_chain[gi]),
        .o_state (w_chain[gi+1]),
        .o_z     (w_z[gi])
      );
    end
  endgenerate

  // In XOR mode a word exists only when data is offered, so gaps consume no keystream
  assign w_run      = (r_state == ST_RUN);
  assign w_word_vld = w_run & (in_valid | ~r_mode);
  assign w_adv      = w_word_vld & out_ready;

  assign out_valid = w_word_vld;
  assign in_ready  = w_run & r_mode & out_ready;
  assign ks_out    = w_word_vld ? (w_z ^ (data_in & {WIDTH{r_mode}})) : '0;
  assign busy      = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
    end else if (load) begin
      r_s    <= load_state(key_in, iv_in);
      r_mode <= mode_in;
      r_cnt  <= '0;
      if (N_ADV == 0) begin
        r_state <= ST_RUN;
        r_busy  <= 1'b0;
      end else begin
        r_state <= ST_INIT;
        r_busy  <= 1'b1;
      end
    end else begin
      case (r_state)
        ST_INIT: begin
          r_s <= w_chain[WIDTH];
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (w_adv) begin
            r_s <= w_chain[WIDTH];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/trivium_stream_gen.md
# trivium_stream_gen

Parametrised Trivium keystream generator. It is the successor to the single-bit Trivium core that sits behind the Tiny Tapeout top-level wrapper. It produces WIDTH keystream bits per clock through an unrolled update network and runs the key/IV warm-up with an internal state machine. Output uses a valid/ready handshake. An optional XOR mode encrypts or decrypts a data stream in place.

## Interface
- WIDTH, 8: keystream bits per advance. Must be a power of two, 1..64.
- INIT_ROUNDS, 1152: warm-up rounds. Must be a multiple of WIDTH. 0 is allowed for debug and skips warm-up.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- key_in  in  80  key; key_in[0] = K1.
- iv_in  in  80  IV; iv_in[0] = IV1.
- mode_in  in  1  0 = raw keystream, 1 = XOR with data_in. Sampled with load.
- load  in  1  single-cycle pulse; latches key, IV and mode, then starts warm-up.
- busy  out  1  high during warm-up.
- data_in  in  WIDTH  plaintext/ciphertext word (XOR mode only).
- in_valid  in  1  data_in valid.
- in_ready  out  1  data_in accepted this cycle when in_valid is also high.
- ks_out  out  WIDTH  output word; bit 0 is the earliest keystream bit.
- out_valid  out  1  ks_out valid.
- out_ready  in  1  consumer accepts ks_out.

## Operation
- State register s[1..288].
- Load: s1..s80 = K1..K80, s81..s93 = 0, s94..s173 = IV1..IV80, s174..s285 = 0, s286..s288 = 1.
- One round:
  - t1 = s66^s93, t2 = s162^s177, t3 = s243^s288; z = t1^t2^t3.
  - t1 ^= s91&s92^s171; t2 ^= s175&s176^s264; t3 ^= s286&s287^s69.
  - Shift: s1..s93 ← (t3, s1..s92); s94..s177 ← (t1, s94..s176); s178..s288 ← (t2, s178..s287).
- One advance applies WIDTH rounds combinationally. ks_out[i] is the z of round i of that advance.
- FSM states are IDLE, INIT and RUN.
  - IDLE: outputs inactive.
  - load (in any state): state loaded, mode latched, counter cleared. Next state is INIT, or RUN if INIT_ROUNDS = 0.
  - INIT: advance every cycle with z discarded, busy = 1. The counter runs to INIT_ROUNDS/WIDTH−1, then goes to RUN.
  - RUN, mode 0: out_valid = 1, in_ready = 0. Advance only on out_valid & out_ready.
  - RUN, mode 1: out_valid = in_valid, in_ready = out_ready, ks_out = z ^ data_in. Advance only on in_valid & out_ready.
- Stall rule: while out_valid is high and out_ready is low, ks_out and state hold stable.
- ks_out is forced to 0 whenever out_valid = 0.
- Reset values: FSM IDLE, s = 0, counter 0, mode 0. busy, out_valid, in_ready and ks_out are all 0.
- load mid-INIT or mid-RUN aborts the current stream. Any pending word is dropped and out_valid falls the next cycle.
- load in the same cycle as a handshake: load wins and the handshake is not counted.
- rst asserted mid-operation returns everything to reset values immediately.

## Timing
- Let load be sampled at edge k and N = INIT_ROUNDS/WIDTH.
  - busy is high from after edge k through edge k+N.
  - The first out_valid (mode 0) is in the cycle after edge k+N, so latency is N+1 cycles.
  - Default parameters give N = 144.
- INIT_ROUNDS = 0: out_valid is high in the cycle after edge k.
- Throughput: one WIDTH-bit word per cycle under continuous out_ready.
- Outputs are combinational from registered state plus data_in. There is no combinational path from out_ready to out_valid.

## Structure
- Package trivium_pkg:
  - state width 288, key/IV width 80, default 1152 rounds;
  - tap index constants (66, 93, 91, 92, 171, 162, 177, 175, 176, 264, 243, 288, 286, 287, 69);
  - FSM state enum.
- Sub-module trivium_round: a combinational single round (state in, state out, z). It is instantiated WIDTH times in a generate chain.
- The top block holds the state register, FSM, counter and handshake logic.

## Test plan
- Reset: assert rst mid-cycle. All outputs go to 0 asynchronously and the FSM is IDLE. Release; with no load, out_valid stays 0.
- Debug vector: WIDTH = 4, INIT_ROUNDS = 0, key = 0, IV = 0, mode 0. The first ks_out is 4'b0111 (z1..z3 = 1, z4 = 0), and the next word is 4'b0000.
- Full warm-up: WIDTH = 8, default rounds, key = 0, IV = 0.
  - busy is high for exactly 144 cycles and out_valid rises on cycle 145.
  - The first 64 bytes match the golden C model.
  - The same key/IV with WIDTH = 1 and WIDTH = 64 gives an identical bit stream.
- Backpressure: hold out_ready = 0 for 5 cycles mid-stream. ks_out is stable and the next words continue without a gap or repeat.
- XOR mode: feed a plaintext stream, then reload the same key/IV and feed the resulting ciphertext. The original plaintext is recovered. in_valid gaps insert no keystream consumption.
- Reload: pulse load mid-INIT and mid-RUN with new values. The stream restarts with full N-cycle latency. A load coinciding with a handshake drops that word.
